// File: rtl/cmt_irq_sched_pkg.sv
// Shared cause codes, FSM state encoding and priority helper for the commit-stage interrupt scheduler.
package cmt_irq_sched_pkg;

   localparam logic [3:0] IRQ_CAUSE_EXT = 4'd11;
   localparam logic [3:0] IRQ_CAUSE_SFT = 4'd3;
   localparam logic [3:0] IRQ_CAUSE_TMR = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_IRQ_REQ   = 2'd1,
      ST_WFI_HALT  = 2'd2,
      ST_WFI_SLEEP = 2'd3
   } irq_state_e;

   // Bit order matches the {ext, sft, tmr} concatenation used by the top.
   typedef struct packed {
      logic ext;
      logic sft;
      logic tmr;
   } irq_vec_t;

   // Fixed priority ext > sft > tmr; only meaningful when at least one bit is set.
   function automatic logic [3:0] irq_pick_cause(irq_vec_t pend);
      if (pend.ext) begin
         return IRQ_CAUSE_EXT;
      end else if (pend.sft) begin
         return IRQ_CAUSE_SFT;
      end else begin
         return IRQ_CAUSE_TMR;
      end
   endfunction

endpackage

// File: rtl/cmt_irq_sched_sync.sv
// Two-stage synchronizer bank for the asynchronous interrupt lines (used under CMT_IRQ_SYNC_EN).
module cmt_irq_sync #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/cmt_irq_sched.sv
// Interrupt scheduler and WFI sequencer for the commit stage.
// Define CMT_IRQ_SYNC_EN to pass the interrupt lines through 2-flop synchronizers (+2 cycles latency).
module cmt_irq_sched
   import cmt_irq_sched_pkg::*;
#(
   parameter int unsigned IRQ_SHADOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ext_irq_i,
   input  logic       sft_irq_i,
   input  logic       tmr_irq_i,
   input  logic       status_mie_r,
   input  logic       meie_r,
   input  logic       msie_r,
   input  logic       mtie_r,
   input  logic       dbg_mode,
   input  logic       cmt_ena,
   input  logic       wfi_req,
   input  logic       halt_ack,
   input  logic       irq_taken,
   output logic       irq_req,
   output logic [3:0] irq_cause,
   output logic       halt_req,
   output logic       core_wfi
);

   localparam logic [1:0] SHADOW_INIT = 2'(IRQ_SHADOW);

   irq_state_e state_q, state_n;
   logic [1:0] shadow_q, shadow_n;
   logic [3:0] cause_q, cause_n;

   logic [2:0] line_raw;
   logic [2:0] line_s;
   irq_vec_t   pend;
   logic       wake;
   logic       eligible;
   logic       wfi_commit;

   assign line_raw = {ext_irq_i, sft_irq_i, tmr_irq_i};

`ifdef CMT_IRQ_SYNC_EN
   logic [2:0] line_sync;

   cmt_irq_sync #(
      .WIDTH (3)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (line_raw),
      .q   (line_sync)
   );

   assign line_s = line_sync;
`else
   assign line_s = line_raw;
`endif

   assign pend       = line_s & {meie_r, msie_r, mtie_r};
   assign wake       = |pend;
   assign eligible   = wake & status_mie_r & ~dbg_mode & (shadow_q == 2'd0);
   assign wfi_commit = cmt_ena & wfi_req & ~dbg_mode;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q  <= ST_IDLE;
         shadow_q <= 2'd0;
         cause_q  <= 4'd0;
      end else begin
         state_q  <= state_n;
         shadow_q <= shadow_n;
         cause_q  <= cause_n;
      end
   end

   always_comb begin
      // NOTE: defaults first so no branch leaves a variable unassigned (no inferred latch).
      state_n  = state_q;
      cause_n  = cause_q;
      shadow_n = (shadow_q != 2'd0) ? shadow_q - 2'd1 : 2'd0;

      unique case (state_q)
         ST_IDLE: begin
            // An eligible interrupt beats a WFI committing in the same cycle.
            if (eligible) begin
               state_n = ST_IRQ_REQ;
               cause_n = irq_pick_cause(pend);
            end else if (wfi_commit) begin
               state_n = ST_WFI_HALT;
            end
         end

         ST_IRQ_REQ: begin
            if (irq_taken) begin
               state_n  = ST_IDLE;
               shadow_n = SHADOW_INIT;
            end
         end

         ST_WFI_HALT, ST_WFI_SLEEP: begin
            // Wake ignores mie; without eligibility execution simply resumes after the WFI.
            if (wake) begin
               if (eligible) begin
                  state_n = ST_IRQ_REQ;
                  cause_n = irq_pick_cause(pend);
               end else begin
                  state_n = ST_IDLE;
               end
            end else if (state_q == ST_WFI_HALT && halt_ack) begin
               state_n = ST_WFI_SLEEP;
            end
         end
      endcase
   end

   assign irq_req   = (state_q == ST_IRQ_REQ);
   assign irq_cause = cause_q;
   assign halt_req  = (state_q == ST_WFI_HALT) || (state_q == ST_WFI_SLEEP);
   assign core_wfi  = (state_q == ST_WFI_SLEEP);

endmodule

// File: tb/tb_cmt_irq_sched.sv
// Self-checking bench for cmt_irq_sched: directed scenarios then random traffic against a flag-level model.
module tb_cmt_irq_sched;

   localparam int SHADOW = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_irq_i, sft_irq_i, tmr_irq_i;
   logic       status_mie_r, meie_r, msie_r, mtie_r;
   logic       dbg_mode, cmt_ena, wfi_req, halt_ack, irq_taken;
   logic       irq_req;
   logic [3:0] irq_cause;
   logic       halt_req;
   logic       core_wfi;

   always #5 clk = ~clk;

   cmt_irq_sched #(
      .IRQ_SHADOW (SHADOW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ext_irq_i    (ext_irq_i),
      .sft_irq_i    (sft_irq_i),
      .tmr_irq_i    (tmr_irq_i),
      .status_mie_r (status_mie_r),
      .meie_r       (meie_r),
      .msie_r       (msie_r),
      .mtie_r       (mtie_r),
      .dbg_mode     (dbg_mode),
      .cmt_ena      (cmt_ena),
      .wfi_req      (wfi_req),
      .halt_ack     (halt_ack),
      .irq_taken    (irq_taken),
      .irq_req      (irq_req),
      .irq_cause    (irq_cause),
      .halt_req     (halt_req),
      .core_wfi     (core_wfi)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Reference model: "trap pending", "halted", "asleep" flags plus cause and shadow count.
   bit m_req, m_halted, m_asleep;
   int m_cause, m_shadow;

   task automatic model_step();
      bit e, s, t, any, ok;
      int best;
      e    = ext_irq_i & meie_r;
      s    = sft_irq_i & msie_r;
      t    = tmr_irq_i & mtie_r;
      any  = e | s | t;
      ok   = any & status_mie_r & ~dbg_mode & (m_shadow == 0);
      best = e ? 11 : (s ? 3 : 7);
      if (rst) begin
         m_req = 0; m_halted = 0; m_asleep = 0; m_cause = 0; m_shadow = 0;
      end else begin
         int shadow_next;
         shadow_next = (m_shadow > 0) ? m_shadow - 1 : 0;
         if (m_req) begin
            if (irq_taken) begin
               m_req = 0;
               shadow_next = SHADOW;
            end
         end else if (m_halted) begin
            if (any) begin
               m_halted = 0;
               m_asleep = 0;
               if (ok) begin
                  m_req = 1;
                  m_cause = best;
               end
            end else if (!m_asleep && halt_ack) begin
               m_asleep = 1;
            end
         end else if (ok) begin
            m_req = 1;
            m_cause = best;
         end else if (cmt_ena & wfi_req & ~dbg_mode) begin
            m_halted = 1;
         end
         m_shadow = shadow_next;
      end
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check({tag, ".irq_req"},   irq_req,   m_req);
      check({tag, ".irq_cause"}, irq_cause, m_cause);
      check({tag, ".halt_req"},  halt_req,  m_halted);
      check({tag, ".core_wfi"},  core_wfi,  m_asleep);
   endtask

   task automatic quiet_inputs();
      rst = 0;
      ext_irq_i = 0; sft_irq_i = 0; tmr_irq_i = 0;
      status_mie_r = 1; meie_r = 1; msie_r = 1; mtie_r = 1;
      dbg_mode = 0; cmt_ena = 0; wfi_req = 0; halt_ack = 0; irq_taken = 0;
   endtask

   initial begin
      quiet_inputs();
      rst = 1;
      cycle("reset");
      check("reset_irq_req", irq_req, 0);
      check("reset_cause", irq_cause, 0);
      check("reset_halt", halt_req, 0);
      check("reset_wfi", core_wfi, 0);
      rst = 0;
      cycle("idle");

      // Priority ext > sft, then shadow delays the follow-up request by one cycle.
      ext_irq_i = 1; sft_irq_i = 1; tmr_irq_i = 1;
      cycle("prio");
      check("prio_req", irq_req, 1);
      check("prio_cause_ext", irq_cause, 11);
      irq_taken = 1; ext_irq_i = 0;
      cycle("prio_take");
      irq_taken = 0;
      cycle("prio_shadow");
      check("shadow_blocks", irq_req, 0);
      cycle("prio_next");
      check("prio_cause_sft", irq_cause, 3);
      sft_irq_i = 0; tmr_irq_i = 0; irq_taken = 1;
      cycle("prio_take2");
      irq_taken = 0;
      repeat (2) cycle("gap");

      // Cause held while the line and enable drop.
      tmr_irq_i = 1;
      cycle("hold_enter");
      check("hold_cause_tmr", irq_cause, 7);
      tmr_irq_i = 0; mtie_r = 0;
      for (int i = 0; i < 4; i++) begin
         cycle("hold");
         check("hold_req", irq_req, 1);
         check("hold_cause", irq_cause, 7);
      end
      irq_taken = 1;
      cycle("hold_take");
      irq_taken = 0; mtie_r = 1;
      repeat (2) cycle("gap");

      // WFI with mie=0: wake resumes without a trap.
      status_mie_r = 0;
      cmt_ena = 1; wfi_req = 1;
      cycle("wfi0_commit");
      check("wfi0_halt_req", halt_req, 1);
      cmt_ena = 0; wfi_req = 0;
      repeat (2) cycle("wfi0_wait");
      halt_ack = 1;
      cycle("wfi0_ack");
      check("wfi0_core_wfi", core_wfi, 1);
      halt_ack = 0;
      sft_irq_i = 1;
      cycle("wfi0_wake");
      check("wfi0_wfi_low", core_wfi, 0);
      check("wfi0_halt_low", halt_req, 0);
      check("wfi0_no_req", irq_req, 0);
      sft_irq_i = 0; status_mie_r = 1;
      cycle("gap");

      // WFI with mie=1: wake goes straight to a trap request.
      cmt_ena = 1; wfi_req = 1;
      cycle("wfi1_commit");
      cmt_ena = 0; wfi_req = 0; halt_ack = 1;
      cycle("wfi1_ack");
      halt_ack = 0; ext_irq_i = 1;
      cycle("wfi1_wake");
      check("wfi1_wfi_low", core_wfi, 0);
      check("wfi1_req", irq_req, 1);
      check("wfi1_cause", irq_cause, 11);
      ext_irq_i = 0; irq_taken = 1;
      cycle("wfi1_take");
      irq_taken = 0;
      repeat (2) cycle("gap");

      // Interrupt and WFI commit together; debug mode masks requests and WFI.
      tmr_irq_i = 1; cmt_ena = 1; wfi_req = 1;
      cycle("simul");
      check("simul_req", irq_req, 1);
      check("simul_no_halt", halt_req, 0);
      cmt_ena = 0; wfi_req = 0; tmr_irq_i = 0; irq_taken = 1;
      cycle("simul_take");
      irq_taken = 0;
      repeat (2) cycle("gap");
      dbg_mode = 1; ext_irq_i = 1;
      repeat (2) cycle("dbg");
      check("dbg_no_req", irq_req, 0);
      ext_irq_i = 0; cmt_ena = 1; wfi_req = 1;
      cycle("dbg_wfi");
      check("dbg_wfi_noop", halt_req, 0);
      quiet_inputs();
      cycle("gap");

      // Reset in IRQ_REQ and in WFI_SLEEP.
      ext_irq_i = 1;
      cycle("rst_req_enter");
      rst = 1; ext_irq_i = 0;
      cycle("rst_req");
      check("rst_req_low", irq_req, 0);
      check("rst_req_cause", irq_cause, 0);
      rst = 0; cmt_ena = 1; wfi_req = 1;
      cycle("rst_wfi_commit");
      cmt_ena = 0; wfi_req = 0; halt_ack = 1;
      cycle("rst_wfi_ack");
      halt_ack = 0; rst = 1;
      cycle("rst_sleep");
      check("rst_sleep_wfi", core_wfi, 0);
      check("rst_sleep_halt", halt_req, 0);
      rst = 0;
      cycle("gap");

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(127) == 0);
         ext_irq_i    = ($urandom_range(3) == 0);
         sft_irq_i    = ($urandom_range(3) == 0);
         tmr_irq_i    = ($urandom_range(3) == 0);
         status_mie_r = ($urandom_range(3) != 0);
         meie_r       = ($urandom_range(3) != 0);
         msie_r       = ($urandom_range(3) != 0);
         mtie_r       = ($urandom_range(3) != 0);
         dbg_mode     = ($urandom_range(15) == 0);
         cmt_ena      = ($urandom_range(1) == 0);
         wfi_req      = ($urandom_range(7) == 0);
         halt_ack     = ($urandom_range(3) == 0);
         irq_taken    = ($urandom_range(2) == 0);
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
